// File: rtl/eth_tx_pktfifo.sv
// Store-and-forward TX packet FIFO between the encap stage and the 10G MAC.
// Latency: a tlast committed at cycle N is presented on m_axis at cycle N+2 (empty FIFO).
// Backpressure: none upstream (s_axis_tready=1); overflow or tuser-marked frames are dropped.
//
// Ports: clk156/eth_rst_n single clock, async active-low reset (sync deassert).
//   s_axis_*    : packet input; tuser on the tlast beat marks a bad frame.
//   m_axis_*    : registered packet output; only fully committed packets are shown.
//   drop_pulse  : one pulse per discarded packet.
// Optional: define ETH_TX_PKTFIFO_STATS_EN to add pkt_count/drop_count (saturating).
module eth_tx_pktfifo #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk156,
  input  logic                  eth_rst_n,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  drop_pulse
`ifdef ETH_TX_PKTFIFO_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [31:0]           drop_count
`endif
);

  localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} wr_state_t;

  // Reset: asserts asynchronously, releases after two clk156 edges.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  // State
  wr_state_t             state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   commit_ptr_q, commit_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  tready_q, tready_d;
  logic                  drop_pulse_q, drop_pulse_d;
  logic                  out_vld_q, out_vld_d;
  logic [WORD_W-1:0]     out_word_q, out_word_d;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic                  mem_we;
  logic [WORD_W-1:0]     mem_rdata;
  logic                  full;

  // Full counts every written beat, committed or not, against the read pointer.
  assign full      = ((wr_ptr_q - rd_ptr_q) == PTR_FULL);
  assign mem_rdata = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign tready_d  = 1'b1;

  // Write side: accept, commit on good tlast, rewind on bad frame or overflow.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_pulse_d = 1'b0;
    mem_we       = 1'b0;
    if (s_axis_tvalid && tready_q) begin
      if (state_q == ST_DROP) begin
        if (s_axis_tlast) state_d = ST_IDLE;
      end else if (full) begin
        wr_ptr_d     = commit_ptr_q;
        drop_pulse_d = 1'b1;
        // An overflowing tlast already ends the packet; don't swallow the next one.
        state_d      = s_axis_tlast ? ST_IDLE : ST_DROP;
      end else begin
        mem_we = 1'b1;
        if (s_axis_tlast) begin
          state_d = ST_IDLE;
          if (s_axis_tuser) begin
            wr_ptr_d     = commit_ptr_q;
            drop_pulse_d = 1'b1;
          end else begin
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
            commit_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end else begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          state_d  = ST_WRITE;
        end
      end
    end
  end

  // Read side: single output register, reloaded whenever empty or being taken.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_word_d = out_word_q;
    if (!out_vld_q || m_axis_tready) begin
      if (rd_ptr_q != commit_ptr_q) begin
        out_word_d = mem_rdata;
        out_vld_d  = 1'b1;
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end else begin
        out_vld_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk156) begin
    if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      tready_q     <= 1'b0;
      drop_pulse_q <= 1'b0;
      out_vld_q    <= 1'b0;
      out_word_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tready_q     <= tready_d;
      drop_pulse_q <= drop_pulse_d;
      out_vld_q    <= out_vld_d;
      out_word_q   <= out_word_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign drop_pulse    = drop_pulse_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_word_q[DATA_WIDTH-1:0];
  assign m_axis_tkeep  = out_word_q[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast  = out_word_q[WORD_W-1];
  assign m_axis_tuser  = 1'b0;

`ifdef ETH_TX_PKTFIFO_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  // A commit always moves commit_ptr, so a pointer change marks one good packet.
  always_comb begin
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    if ((commit_ptr_d != commit_ptr_q) && (pkt_count_q != 32'hFFFF_FFFF))
      pkt_count_d = pkt_count_q + 32'd1;
    if (drop_pulse_d && (drop_count_q != 32'hFFFF_FFFF))
      drop_count_d = drop_count_q + 32'd1;
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_eth_tx_pktfifo.sv
// Randomized bench for eth_tx_pktfifo with a packet-level reference model.
// Latency: checks first-beat timing on an idle FIFO.
// Backpressure: drives m_axis_tready held low, held high, or random.
`timescale 1ns/1ps
module tb_eth_tx_pktfifo;

  localparam int DEPTH = 512;

  logic        clk156;
  logic        eth_rst_n;
  logic        s_axis_tvalid;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready;
  logic        drop_pulse;
`ifdef ETH_TX_PKTFIFO_STATS_EN
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
`endif

  eth_tx_pktfifo dut (
    .clk156        (clk156),
    .eth_rst_n     (eth_rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .drop_pulse    (drop_pulse)
`ifdef ETH_TX_PKTFIFO_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 1;        // 0 hold low, 1 hold high, 2 random
  bit hold_model = 0;      // output stalled: capacity decides packet fate
  int committed_beats = 0;
  int exp_drops = 0;
  int drop_seen = 0;
  int out_beats = 0;
  int stat_good = 0;
  int stat_drop = 0;
  logic [72:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    clk156 = 1'b0;
    forever #5 clk156 = ~clk156;
  end

  initial forever begin
    @(posedge clk156);
    cyc++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk156);
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ($urandom_range(99) < 80);
    endcase
  end

  // Output monitor / scoreboard.
  initial begin
    logic [72:0] cur, prev_word, w;
    bit mid_pkt, prev_stall;
    mid_pkt = 0; prev_stall = 0; prev_word = '0;
    forever begin
      @(negedge clk156);
      if (!eth_rst_n) begin
        exp_q.delete();
        mid_pkt = 0;
        prev_stall = 0;
      end else begin
        if (drop_pulse) drop_seen++;
        cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (prev_stall) chk("stall_hold", {m_axis_tvalid, cur}, {1'b1, prev_word});
        if (mid_pkt && m_axis_tready) chk("no_gap", m_axis_tvalid, 1);
        if (m_axis_tvalid && m_axis_tready) begin
          out_beats++;
          chk("tuser_zero", m_axis_tuser, 0);
          chk("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("beat_data", cur, w);
          end
          mid_pkt = !m_axis_tlast;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_word  = cur;
      end
    end
  end

  // Send one packet; the model decides its fate from length, tuser and free space.
  task automatic send_pkt(input int len, input bit bad, input int gap_pct,
                          input logic [7:0] keep_last, output int t_last);
    logic [72:0] beats[$];
    logic [72:0] w;
    bit fits;
    t_last = 0;
    fits = (len <= DEPTH) && (!hold_model || (committed_beats + len <= DEPTH));
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk156); #1;
      end
      w[63:0]  = {$urandom, $urandom};
      w[71:64] = (i == len - 1) ? keep_last : 8'hFF;
      w[72]    = (i == len - 1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = w[63:0];
      s_axis_tkeep  = w[71:64];
      s_axis_tlast  = w[72];
      s_axis_tuser  = bad && (i == len - 1);
      beats.push_back(w);
      if (i == len - 1) begin
        t_last = cyc;
        if (!bad && fits) begin
          foreach (beats[k]) exp_q.push_back(beats[k]);
          committed_beats += len;
          stat_good++;
        end else begin
          exp_drops++;
          stat_drop++;
        end
      end
      @(posedge clk156); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk156);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk156);
    #1;
  endtask

  initial begin
    int tl, seen, b0;
    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 0; s_axis_tuser = 0; m_axis_tready = 1;
    eth_rst_n = 1'b1;
    #2 eth_rst_n = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_tready", s_axis_tready, 0);
    eth_rst_n = 1'b1;
    repeat (5) @(posedge clk156);
    #1;
    chk("tready_after_rst", s_axis_tready, 1);

    // 8-beat good packet, latency and last-beat tkeep.
    send_pkt(8, 0, 0, 8'h0F, tl);
    seen = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk156);
      if (m_axis_tvalid) begin
        seen = cyc;
        break;
      end
    end
    chk("first_beat_latency", seen - tl, 2);
    wait_drain(200);
    chk("good_no_drop", drop_seen, exp_drops);

    // Bad frame followed by a good one.
    send_pkt(4, 1, 0, 8'hFF, tl);
    send_pkt(3, 0, 0, 8'h07, tl);
    wait_drain(200);
    chk("bad_frame_drop", drop_seen, exp_drops);

    // Stalled output: 10 x 60-beat packets, then release.
    rdy_mode = 0;
    repeat (2) @(posedge clk156);
    #1;
    hold_model = 1;
    committed_beats = 0;
    for (int p = 0; p < 10; p++) send_pkt(60, 0, 0, 8'h3F, tl);
    repeat (3) @(posedge clk156);
    #1;
    chk("overflow_drops", drop_seen, exp_drops);
    chk("overflow_queued", exp_q.size(), 480);
    hold_model = 0;
    rdy_mode = 1;
    wait_drain(2000);
    for (int p = 0; p < 3; p++) send_pkt(60, 0, 10, 8'h01, tl);
    wait_drain(500);
    chk("after_overflow_drops", drop_seen, exp_drops);

    // Oversized packet.
    b0 = out_beats;
    send_pkt(520, 0, 0, 8'hFF, tl);
    repeat (4) @(posedge clk156);
    #1;
    chk("long_pkt_no_output", out_beats - b0, 0);
    chk("long_pkt_drop", drop_seen, exp_drops);
    send_pkt(2, 0, 0, 8'h03, tl);
    wait_drain(200);

    // Random traffic with random tready, across many pointer wraps.
    rdy_mode = 2;
    for (int p = 0; p < 1000; p++)
      send_pkt($urandom_range(64, 1), ($urandom_range(15) == 0), 33,
               8'($urandom_range(255, 1)), tl);
    wait_drain(5000);
    rdy_mode = 1;
    repeat (2) @(posedge clk156);
    #1;
    chk("random_drops", drop_seen, exp_drops);
`ifdef ETH_TX_PKTFIFO_STATS_EN
    chk("stat_pkt_count", pkt_count, stat_good);
    chk("stat_drop_count", drop_count, stat_drop);
`endif

    // Reset in the middle of an output packet.
    send_pkt(40, 0, 0, 8'hFF, tl);
    repeat (6) @(posedge clk156);
    #1;
    #1 eth_rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", m_axis_tvalid, 0);
    chk("async_rst_tready", s_axis_tready, 0);
    repeat (3) @(posedge clk156);
    #1;
    eth_rst_n = 1'b1;
    stat_good = 0;
    stat_drop = 0;
    repeat (5) @(posedge clk156);
    #1;
    chk("post_rst_empty", m_axis_tvalid, 0);
    chk("post_rst_tready", s_axis_tready, 1);
`ifdef ETH_TX_PKTFIFO_STATS_EN
    chk("post_rst_pkt_count", pkt_count, 0);
    chk("post_rst_drop_count", drop_count, 0);
`endif
    b0 = out_beats;
    send_pkt(5, 0, 0, 8'h1F, tl);
    wait_drain(200);
    chk("post_rst_beats", out_beats - b0, 5);
    chk("final_drops", drop_seen, exp_drops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
